// File: rtl/voice_mixer_if.sv
// voice_mixer_if: sample/register/status bundle between the voice array, the register bus and the mixer.
//   master: drives strobe, voice samples and register writes; observes mixed sample and status.
//   slave : the mixer side.
interface voice_mixer_if #(
    parameter int NUM_VOICES   = 8,
    parameter int SAMPLE_WIDTH = 24
);
    logic                                 i_SampleStrobe;
    logic [NUM_VOICES*SAMPLE_WIDTH-1:0]   i_VoiceSamples;
    logic [7:0]                           i_RegisterNumber;
    logic [23:0]                          i_RegisterValue;
    logic                                 i_RegisterWriteEnable;
    logic signed [SAMPLE_WIDTH-1:0]       o_Sample;
    logic                                 o_SampleValid;
    logic                                 o_Clip;
    logic                                 o_Busy;
    logic                                 o_Overrun;
    modport master (
        output i_SampleStrobe, i_VoiceSamples, i_RegisterNumber, i_RegisterValue, i_RegisterWriteEnable,
        input  o_Sample, o_SampleValid, o_Clip, o_Busy, o_Overrun
    );
    modport slave (
        input  i_SampleStrobe, i_VoiceSamples, i_RegisterNumber, i_RegisterValue, i_RegisterWriteEnable,
        output o_Sample, o_SampleValid, o_Clip, o_Busy, o_Overrun
    );
endinterface

// File: rtl/voice_mixer.sv
// voice_mixer: time-multiplexed gain mixer of NUM_VOICES signed voices with mute and output saturation.
//   i_Clock, i_Reset : clock and synchronous active-high reset.
//   bus (slave)      : sample strobe and voice samples in, register writes (gain 0..N-1, mute 0x80,
//                      overrun clear 0x81), mixed sample / valid / clip / busy / overrun out.
module voice_mixer #(
    parameter int NUM_VOICES   = 8,
    parameter int SAMPLE_WIDTH = 24,
    parameter int GAIN_WIDTH   = 16
) (
    input logic           i_Clock,
    input logic           i_Reset,
    voice_mixer_if.slave  bus
);
    localparam int PW = SAMPLE_WIDTH + GAIN_WIDTH + 1;
    localparam int AW = PW + $clog2(NUM_VOICES + 1);
    localparam int IW = NUM_VOICES > 1 ? $clog2(NUM_VOICES) : 1;
    localparam logic signed [AW-1:0] MAXV = {{(AW-SAMPLE_WIDTH+1){1'b0}}, {(SAMPLE_WIDTH-1){1'b1}}};
    localparam logic signed [AW-1:0] MINV = ~MAXV;
    typedef enum logic [1:0] {IDLE, ACCUM, FINISH} state_t;
    state_t                             state_q, state_d;
    logic [GAIN_WIDTH-1:0]              gain_q [NUM_VOICES];
    logic [GAIN_WIDTH-1:0]              gain_d [NUM_VOICES];
    logic                               mute_q, mute_d;
    logic [NUM_VOICES*SAMPLE_WIDTH-1:0] snap_q, snap_d;
    logic [IW-1:0]                      idx_q, idx_d;
    logic signed [AW-1:0]               acc_q, acc_d;
    logic signed [SAMPLE_WIDTH-1:0]     sample_q, sample_d;
    logic                               clip_q, clip_d;
    logic                               valid_q, valid_d;
    logic                               overrun_q, overrun_d;
    logic signed [SAMPLE_WIDTH-1:0]     cur;
    logic signed [PW-1:0]               prod;
    logic signed [AW-1:0]               shifted;
    logic                               hi, lo;
    // Gain is unsigned, so it gets a zero sign bit before the signed multiply.
    assign cur     = snap_q[idx_q*SAMPLE_WIDTH +: SAMPLE_WIDTH];
    assign prod    = cur * $signed({1'b0, gain_q[idx_q]});
    assign shifted = acc_q >>> (GAIN_WIDTH - 1);
    assign hi      = shifted > MAXV;
    assign lo      = shifted < MINV;
    always_comb begin
        state_d   = state_q;
        gain_d    = gain_q;
        mute_d    = mute_q;
        snap_d    = snap_q;
        idx_d     = idx_q;
        acc_d     = acc_q;
        sample_d  = sample_q;
        clip_d    = clip_q;
        valid_d   = 1'b0;
        overrun_d = overrun_q;
        if (bus.i_RegisterWriteEnable) begin
            for (int v = 0; v < NUM_VOICES; v++)
                if (bus.i_RegisterNumber == 8'(v)) gain_d[v] = bus.i_RegisterValue[GAIN_WIDTH-1:0];
            if (bus.i_RegisterNumber == 8'h80) mute_d = bus.i_RegisterValue[0];
            if (bus.i_RegisterNumber == 8'h81) overrun_d = 1'b0;
        end
        // Placed after the clear so a simultaneous overrun strobe wins.
        if (bus.i_SampleStrobe && state_q != IDLE) overrun_d = 1'b1;
        case (state_q)
            IDLE: if (bus.i_SampleStrobe) begin
                snap_d  = bus.i_VoiceSamples;
                acc_d   = '0;
                idx_d   = '0;
                state_d = ACCUM;
            end
            ACCUM: begin
                acc_d   = acc_q + prod;
                idx_d   = idx_q + 1'b1;
                state_d = idx_q == IW'(NUM_VOICES - 1) ? FINISH : ACCUM;
            end
            FINISH: begin
                sample_d = mute_q ? '0 : hi ? MAXV[SAMPLE_WIDTH-1:0] : lo ? MINV[SAMPLE_WIDTH-1:0] : shifted[SAMPLE_WIDTH-1:0];
                clip_d   = !mute_q && (hi || lo);
                valid_d  = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q   <= IDLE;
            gain_q    <= '{default: '0};
            mute_q    <= 1'b0;
            snap_q    <= '0;
            idx_q     <= '0;
            acc_q     <= '0;
            sample_q  <= '0;
            clip_q    <= 1'b0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gain_q    <= gain_d;
            mute_q    <= mute_d;
            snap_q    <= snap_d;
            idx_q     <= idx_d;
            acc_q     <= acc_d;
            sample_q  <= sample_d;
            clip_q    <= clip_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end
    assign bus.o_Sample      = sample_q;
    assign bus.o_Clip        = clip_q;
    assign bus.o_SampleValid = valid_q;
    assign bus.o_Busy        = state_q != IDLE;
    assign bus.o_Overrun     = overrun_q;
endmodule

// File: tb/tb_voice_mixer.sv
// tb_voice_mixer: vector table, corner sequences and randomized mixes against a reference model.
module tb_voice_mixer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad = 0;
    logic [3:0][15:0] gsh;
    bit               msh;
    always #5 clk = ~clk;
    voice_mixer_if #(.NUM_VOICES(4), .SAMPLE_WIDTH(24)) bus();
    voice_mixer #(.NUM_VOICES(4), .SAMPLE_WIDTH(24), .GAIN_WIDTH(16)) dut (
        .i_Clock(clk),
        .i_Reset(rst),
        .bus(bus)
    );
    typedef struct packed {
        logic [3:0][23:0] s;
        logic [3:0][15:0] g;
        logic             m;
        logic [23:0]      es;
        logic             ec;
    } vec_t;
    vec_t vecs [6];
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(string n, logic [31:0] a, logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", n, a, e);
        end
    endtask
    task automatic wr(logic [7:0] num, logic [23:0] val);
        bus.i_RegisterNumber = num;
        bus.i_RegisterValue = val;
        bus.i_RegisterWriteEnable = 1'b1;
        tick();
        bus.i_RegisterWriteEnable = 1'b0;
    endtask
    task automatic cfg(logic [3:0][15:0] g, bit m);
        for (int i = 0; i < 4; i++) wr(8'(i), {8'h0, g[i]});
        wr(8'h80, {23'h0, m});
        gsh = g;
        msh = m;
    endtask
    task automatic start();
        bus.i_SampleStrobe = 1'b1;
        tick();
        bus.i_SampleStrobe = 1'b0;
    endtask
    // Checks 'left' busy, non-valid cycles, then the valid cycle.
    task automatic finish(string n, int left, logic [23:0] es, bit ec);
        for (int k = 0; k < left; k++) begin
            chk({n, "_busy"}, 32'(bus.o_Busy), 32'd1);
            chk({n, "_early_valid"}, 32'(bus.o_SampleValid), 32'd0);
            tick();
        end
        chk({n, "_valid"}, 32'(bus.o_SampleValid), 32'd1);
        chk({n, "_idle"}, 32'(bus.o_Busy), 32'd0);
        chk({n, "_sample"}, 32'(bus.o_Sample[23:0]), 32'(es));
        chk({n, "_clip"}, 32'(bus.o_Clip), 32'(ec));
    endtask
    function automatic void model(logic [3:0][23:0] s, logic [3:0][15:0] g, bit m, output logic [23:0] es, output bit ec);
        longint acc = 0;
        longint r;
        for (int i = 0; i < 4; i++) acc += longint'($signed(s[i])) * longint'(g[i]);
        r = acc / 32768;
        if (acc < 0 && acc % 32768 != 0) r -= 1;
        ec = 1'b0;
        if (r > 64'sd8388607) begin
            r = 8388607;
            ec = 1'b1;
        end else if (r < -64'sd8388608) begin
            r = -8388608;
            ec = 1'b1;
        end
        es = r[23:0];
        if (m) begin
            es = '0;
            ec = 1'b0;
        end
    endfunction
    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end
    initial begin
        logic [3:0][23:0] s;
        logic [3:0][15:0] g;
        logic [23:0]      es;
        bit               ec;
        bus.i_SampleStrobe = 1'b0;
        bus.i_VoiceSamples = '0;
        bus.i_RegisterNumber = '0;
        bus.i_RegisterValue = '0;
        bus.i_RegisterWriteEnable = 1'b0;
        vecs[0] = '{s: {24'd400, 24'd300, 24'd200, 24'd100}, g: {4{16'h8000}}, m: 1'b0, es: 24'd1000, ec: 1'b0};
        vecs[1] = '{s: {4{24'h7FFFFF}}, g: {4{16'h8000}}, m: 1'b0, es: 24'h7FFFFF, ec: 1'b1};
        vecs[2] = '{s: {4{24'h800000}}, g: {4{16'h8000}}, m: 1'b0, es: 24'h800000, ec: 1'b1};
        vecs[3] = '{s: {24'd5, 24'd5, 24'd5, 24'hFFFFFD}, g: {16'h0, 16'h0, 16'h0, 16'h4000}, m: 1'b0, es: 24'hFFFFFE, ec: 1'b0};
        vecs[4] = '{s: {24'd5, 24'd5, 24'd5, 24'hFFFFFD}, g: {16'h0, 16'h0, 16'h0, 16'h4000}, m: 1'b1, es: 24'h0, ec: 1'b0};
        vecs[5] = '{s: {24'd0, 24'd7, 24'hFFFE0C, 24'd1000}, g: {16'h0, 16'hFFFF, 16'h4000, 16'h8000}, m: 1'b0, es: 24'd763, ec: 1'b0};
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("rst_sample", 32'(bus.o_Sample[23:0]), 32'd0);
        chk("rst_valid", 32'(bus.o_SampleValid), 32'd0);
        chk("rst_clip", 32'(bus.o_Clip), 32'd0);
        chk("rst_busy", 32'(bus.o_Busy), 32'd0);
        chk("rst_overrun", 32'(bus.o_Overrun), 32'd0);
        for (int i = 0; i < 6; i++) begin
            cfg(vecs[i].g, vecs[i].m);
            bus.i_VoiceSamples = vecs[i].s;
            start();
            finish($sformatf("vec%0d", i), 5, vecs[i].es, vecs[i].ec);
            tick();
            chk($sformatf("vec%0d_pulse_end", i), 32'(bus.o_SampleValid), 32'd0);
        end
        // Gain write landing while voice 0 accumulates: old gain still applies.
        cfg({4{16'h8000}}, 1'b0);
        bus.i_VoiceSamples = {4{24'd100}};
        start();
        wr(8'h00, 24'h0);
        finish("gain_race", 4, 24'd400, 1'b0);
        // Overrun: second strobe two edges after the first is dropped.
        cfg({4{16'h8000}}, 1'b0);
        bus.i_VoiceSamples = {24'd4, 24'd3, 24'd2, 24'd1};
        start();
        tick();
        chk("ovr_before", 32'(bus.o_Overrun), 32'd0);
        start();
        chk("ovr_set", 32'(bus.o_Overrun), 32'd1);
        finish("ovr_mix", 3, 24'd10, 1'b0);
        for (int k = 0; k < 7; k++) begin
            tick();
            chk("ovr_no_second", 32'(bus.o_SampleValid), 32'd0);
        end
        start();
        bus.i_SampleStrobe = 1'b1;
        wr(8'h81, 24'h0);
        bus.i_SampleStrobe = 1'b0;
        chk("ovr_set_wins", 32'(bus.o_Overrun), 32'd1);
        finish("ovr_mix2", 4, 24'd10, 1'b0);
        wr(8'h81, 24'h0);
        chk("ovr_clear", 32'(bus.o_Overrun), 32'd0);
        // Snapshot then back-to-back strobe in the valid cycle.
        bus.i_VoiceSamples = {24'd40, 24'd30, 24'd20, 24'd10};
        start();
        bus.i_VoiceSamples = {4{24'd1000}};
        finish("snap", 5, 24'd100, 1'b0);
        start();
        finish("b2b", 5, 24'd4000, 1'b0);
        // Reset mid-mix.
        bus.i_VoiceSamples = {4{24'd50}};
        start();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_busy", 32'(bus.o_Busy), 32'd0);
        chk("mid_rst_sample", 32'(bus.o_Sample[23:0]), 32'd0);
        chk("mid_rst_valid", 32'(bus.o_SampleValid), 32'd0);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("mid_rst_no_valid", 32'(bus.o_SampleValid), 32'd0);
        end
        gsh = '0;
        msh = 1'b0;
        start();
        finish("post_rst", 5, 24'd0, 1'b0);
        // Randomized mixes against the model.
        for (int it = 0; it < 24; it++) begin
            for (int i = 0; i < 4; i++) begin
                s[i] = 24'($urandom);
                g[i] = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
            end
            if (it % 5 == 0) s = {4{($urandom_range(0, 1) == 1) ? 24'h7FF000 : 24'h801000}};
            cfg(g, $urandom_range(0, 4) == 0);
            bus.i_VoiceSamples = s;
            model(s, gsh, msh, es, ec);
            start();
            finish($sformatf("rnd%0d", it), 5, es, ec);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/voice_mixer.md
# voice_mixer

Parametrised, time-multiplexed mixer that combines the signed outputs of `NUM_VOICES` voice instances into a single output sample. It replaces fixed divide-by-N averaging with programmable per-voice gain, master mute, and output saturation. It sits between the voice array and the output stage. Gain and control registers are written through the same 8-bit-number / 24-bit-value register write port used for voice registers.

## Interface
- `NUM_VOICES`, default 8: voice count; legal range 1..128.
- `SAMPLE_WIDTH`, default 24: signed sample width, for both input and output.
- `GAIN_WIDTH`, default 16: unsigned gain width, 2..24. Gain g scales by g / 2^(GAIN_WIDTH-1), so 0x8000 = 1.0.
- `i_Clock`  in  1  clock.
- `i_Reset`  in  1  synchronous, active-high reset.
- `i_SampleStrobe`  in  1  request one mixed sample.
- `i_VoiceSamples`  in  NUM_VOICES*SAMPLE_WIDTH  signed voice samples; voice v occupies bits [v*SAMPLE_WIDTH +: SAMPLE_WIDTH].
- `i_RegisterNumber`  in  8  register address.
- `i_RegisterValue`  in  24  write data.
- `i_RegisterWriteEnable`  in  1  write strobe.
- `o_Sample`  out  SAMPLE_WIDTH  signed mixed sample; holds its value between updates.
- `o_SampleValid`  out  1  one-cycle pulse when `o_Sample` updates.
- `o_Clip`  out  1  saturation occurred for the current `o_Sample`; updates together with `o_Sample`.
- `o_Busy`  out  1  mix in progress.
- `o_Overrun`  out  1  sticky: a strobe arrived while busy.

## Operation
- Register map, writes only:
  - 0x00..NUM_VOICES-1: gain[v] <= value[GAIN_WIDTH-1:0].
  - 0x80: mute <= value[0].
  - 0x81: any write clears `o_Overrun`.
  - All other addresses are ignored.
- Reset values:
  - All gains = 0, mute = 0.
  - `o_Sample` = 0, `o_SampleValid` = 0, `o_Clip` = 0, `o_Busy` = 0, `o_Overrun` = 0.
  - State = IDLE, accumulator = 0.
- FSM states are IDLE, ACCUM, FINISH.
  - IDLE + `i_SampleStrobe`: snapshot all of `i_VoiceSamples`, clear the accumulator, set voice index = 0, go to ACCUM.
  - ACCUM: acc += snap[idx] * $signed({1'b0, gain[idx]}); idx++. After voice NUM_VOICES-1, go to FINISH.
  - FINISH: compute r = acc >>> (GAIN_WIDTH-1) (arithmetic shift, floor), then saturate r to [-2^(SAMPLE_WIDTH-1), 2^(SAMPLE_WIDTH-1)-1].
    - Register the result into `o_Sample`, and set `o_Clip` = 1 if saturation changed the value.
    - If mute = 1: `o_Sample` = 0 and `o_Clip` = 0.
    - Pulse `o_SampleValid` and return to IDLE.
- Widths:
  - Product: SAMPLE_WIDTH+GAIN_WIDTH+1 bits.
  - Accumulator: SAMPLE_WIDTH+GAIN_WIDTH+1+$clog2(NUM_VOICES+1) bits, so the accumulator itself never overflows.
- Gain and mute are read live.
  - A gain write lands at the clock edge. An ACCUM step for the same voice in that same cycle uses the old value.
  - Mute is sampled in FINISH.
  - Samples are taken only from the snapshot; `i_VoiceSamples` changes after acceptance have no effect.
- A strobe in ACCUM or FINISH is dropped; `o_Overrun` <= 1.
  - If a 0x81 write and an overrun strobe occur in the same cycle, the set wins.
- A register write and a strobe in the same cycle are both honoured.
- A reset mid-mix aborts immediately: no `o_SampleValid`, everything returns to reset values.

## Timing
- Strobe sampled high in IDLE at edge T.
  - ACCUM occupies cycles T+1..T+NUM_VOICES; voice v is accumulated in cycle T+1+v.
  - FINISH is cycle T+NUM_VOICES+1.
  - `o_Sample`, `o_Clip` and `o_SampleValid` are visible in cycle T+NUM_VOICES+2.
  - Latency is NUM_VOICES+2 cycles.
- `o_Busy` is high in cycles T+1..T+NUM_VOICES+1 and low in the `o_SampleValid` cycle.
- A strobe in the `o_SampleValid` cycle is accepted, since the FSM is in IDLE. Maximum throughput is one sample per NUM_VOICES+2 cycles.
- `o_SampleValid` is exactly one cycle wide. `o_Sample` and `o_Clip` hold until the next FINISH or reset.

## Test plan
1. **Basic sum.** NUM_VOICES=4, all gains 0x8000, samples 100/200/300/400; strobe at T. Required: `o_Sample` = 1000 and `o_SampleValid` = 1 only in cycle T+6; `o_Clip` = 0; `o_Busy` high T+1..T+5.
2. **Saturation.** Gains 0x8000, all samples 0x7FFFFF. Required: `o_Sample` = 0x7FFFFF, `o_Clip` = 1. Repeat with all samples 0x800000: `o_Sample` = 0x800000, `o_Clip` = 1.
3. **Scaling and floor.** gain[0] = 0x4000, sample0 = -3, other gains 0. Required: `o_Sample` = 0xFFFFFE (-2). Then write mute = 1 and re-strobe: `o_Sample` = 0, `o_Clip` = 0.
4. **Overrun.** Strobe at T and again at T+2. Required: exactly one valid pulse, at T+6; `o_Overrun` = 1 from T+3. Write 0x81: `o_Overrun` = 0 on the next cycle.
5. **Reset mid-mix.** Assert reset at T+2. Required: no valid pulse; next cycle `o_Busy` = 0, `o_Sample` = 0, gains = 0. A new strobe then yields 0.
6. **Snapshot and back-to-back.** Change `i_VoiceSamples` at T+1; required: the output reflects values at T. Strobe again in the `o_SampleValid` cycle; required: accepted, next valid 6 cycles later.
